// File: rtl/branch_pred_ctrl_if.sv
// branch_pred_ctrl_if: fetch-predict, execute-resolve, comparator and redirect/flush/count signals of branch_pred_ctrl
interface branch_pred_ctrl_if;
  logic [31:0] f_pc_i;
  logic        f_pred_taken_o;
  logic        x_valid_i;
  logic        x_is_br_i;
  logic [2:0]  x_funct3_i;
  logic [31:0] x_pc_i;
  logic [31:0] x_target_i;
  logic        x_pred_taken_i;
  logic        br_un_o;
  logic        br_eq_i;
  logic        br_lt_i;
  logic        redirect_o;
  logic [31:0] redirect_pc_o;
  logic        flush_o;
  logic [31:0] br_cnt_o;
  logic [31:0] mispred_cnt_o;
  modport master (
    output f_pc_i, x_valid_i, x_is_br_i, x_funct3_i, x_pc_i, x_target_i, x_pred_taken_i, br_eq_i, br_lt_i,
    input  f_pred_taken_o, br_un_o, redirect_o, redirect_pc_o, flush_o, br_cnt_o, mispred_cnt_o
  );
  modport slave (
    input  f_pc_i, x_valid_i, x_is_br_i, x_funct3_i, x_pc_i, x_target_i, x_pred_taken_i, br_eq_i, br_lt_i,
    output f_pred_taken_o, br_un_o, redirect_o, redirect_pc_o, flush_o, br_cnt_o, mispred_cnt_o
  );
endinterface

// File: rtl/branch_pred_ctrl.sv
// branch_pred_ctrl: branch taken decode, 2-bit bimodal table and mispredict redirect/flush FSM (clk_i, rst_n_i, bus: slave side of branch_pred_ctrl_if)
module branch_pred_ctrl #(
  parameter int IDX_W     = 4,
  parameter int FLUSH_CYC = 2
) (
  input logic              clk_i,
  input logic              rst_n_i,
  branch_pred_ctrl_if.slave bus
);
  typedef enum logic {IDLE, FLUSH} state_t;
  state_t           state, state_d;
  logic [3:0]       cnt, cnt_d;
  logic [1:0]       tbl [2**IDX_W];
  logic [IDX_W-1:0] x_idx, f_idx;
  logic             legal, taken, resolve, mispred;
  assign x_idx              = bus.x_pc_i[IDX_W+1:2];
  assign f_idx              = bus.f_pc_i[IDX_W+1:2];
  assign bus.br_un_o        = bus.x_funct3_i[1];
  assign bus.f_pred_taken_o = tbl[f_idx][1];
  assign bus.flush_o        = state == FLUSH;
  assign legal              = bus.x_funct3_i[2] | ~bus.x_funct3_i[1];
  assign taken              = (bus.x_funct3_i[2] ? bus.br_lt_i : bus.br_eq_i) ^ bus.x_funct3_i[0];
  assign resolve            = bus.x_valid_i & bus.x_is_br_i & legal & (state == IDLE);
  assign mispred            = resolve & (taken != bus.x_pred_taken_i);
  always_comb begin
    state_d = state == IDLE ? (mispred ? FLUSH : IDLE) : (cnt == 4'd0 ? IDLE : FLUSH);
    cnt_d   = state == IDLE ? 4'(FLUSH_CYC - 1) : cnt - 4'd1;
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < 2**IDX_W; i++) tbl[i] <= 2'b01;
      bus.redirect_o    <= 1'b0;
      bus.redirect_pc_o <= 32'd0;
      bus.br_cnt_o      <= 32'd0;
      bus.mispred_cnt_o <= 32'd0;
    end else begin
      bus.redirect_o <= mispred;
      if (mispred) begin
        bus.redirect_pc_o <= taken ? bus.x_target_i : bus.x_pc_i + 32'd4;
        bus.mispred_cnt_o <= bus.mispred_cnt_o + 32'd1;
      end
      if (resolve) begin
        bus.br_cnt_o <= bus.br_cnt_o + 32'd1;
        tbl[x_idx]   <= taken ? (tbl[x_idx] == 2'b11 ? 2'b11 : tbl[x_idx] + 2'b01)
                              : (tbl[x_idx] == 2'b00 ? 2'b00 : tbl[x_idx] - 2'b01);
      end
    end
  end
endmodule

// File: tb/tb_branch_pred_ctrl.sv
// tb_branch_pred_ctrl: vector-table and scoreboard bench for branch_pred_ctrl
module tb_branch_pred_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  always #5 clk = ~clk;
  branch_pred_ctrl_if bus ();
  branch_pred_ctrl #(.IDX_W(4), .FLUSH_CYC(2)) dut (.clk_i(clk), .rst_n_i(rst_n), .bus(bus.slave));
  typedef struct {
    logic [31:0] f_pc;
    logic        v, br;
    logic [2:0]  f3;
    logic [31:0] pc, tgt;
    logic        pred, eq, lt;
    logic        e_fp, e_un, e_rd;
    logic [31:0] e_rpc;
    logic        e_fl;
    logic [31:0] e_bc, e_mc;
  } vec_t;
  vec_t vecs[$];
  vec_t exp_q[$];
  function automatic vec_t mk(logic [31:0] f_pc, logic v, logic br, logic [2:0] f3, logic [31:0] pc, logic [31:0] tgt,
                              logic pred, logic eq, logic lt, logic e_fp, logic e_un, logic e_rd, logic [31:0] e_rpc,
                              logic e_fl, logic [31:0] e_bc, logic [31:0] e_mc);
    vec_t r;
    r = '{f_pc, v, br, f3, pc, tgt, pred, eq, lt, e_fp, e_un, e_rd, e_rpc, e_fl, e_bc, e_mc};
    return r;
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic drive(logic [31:0] f_pc, logic v, logic br, logic [2:0] f3, logic [31:0] pc, logic [31:0] tgt,
                       logic pred, logic eq, logic lt);
    bus.f_pc_i = f_pc; bus.x_valid_i = v; bus.x_is_br_i = br; bus.x_funct3_i = f3;
    bus.x_pc_i = pc; bus.x_target_i = tgt; bus.x_pred_taken_i = pred; bus.br_eq_i = eq; bus.br_lt_i = lt;
  endtask
  initial begin
    vec_t e;
    //           f_pc          v  br f3    x_pc          tgt          pr eq lt  fp un  rd rpc           fl bc  mc
    vecs.push_back(mk(32'h100, 0, 0, 3'd0, 32'h0,        32'h0,       0, 0, 0,  0, 0,  0, 32'h0,        0, 0,  0));
    vecs.push_back(mk(32'h100, 1, 1, 3'd0, 32'h100,      32'h200,     0, 1, 0,  0, 0,  1, 32'h200,      1, 1,  1));
    vecs.push_back(mk(32'h100, 1, 1, 3'd0, 32'h100,      32'h200,     0, 1, 0,  1, 0,  0, 32'h200,      1, 1,  1));
    vecs.push_back(mk(32'h100, 1, 1, 3'd0, 32'h100,      32'h200,     0, 1, 0,  1, 0,  0, 32'h200,      0, 1,  1));
    vecs.push_back(mk(32'h100, 1, 1, 3'd0, 32'h100,      32'h200,     0, 1, 0,  1, 0,  1, 32'h200,      1, 2,  2));
    vecs.push_back(mk(32'h100, 0, 0, 3'd0, 32'h0,        32'h0,       0, 0, 0,  1, 0,  0, 32'h200,      1, 2,  2));
    vecs.push_back(mk(32'h100, 0, 0, 3'd0, 32'h0,        32'h0,       0, 0, 0,  1, 0,  0, 32'h200,      0, 2,  2));
    vecs.push_back(mk(32'h104, 1, 1, 3'd7, 32'h104,      32'h300,     1, 0, 1,  0, 1,  1, 32'h108,      1, 3,  3));
    vecs.push_back(mk(32'h104, 0, 0, 3'd0, 32'h0,        32'h0,       0, 0, 0,  0, 0,  0, 32'h108,      1, 3,  3));
    vecs.push_back(mk(32'h104, 0, 0, 3'd0, 32'h0,        32'h0,       0, 0, 0,  0, 0,  0, 32'h108,      0, 3,  3));
    vecs.push_back(mk(32'h104, 1, 1, 3'd7, 32'h104,      32'h300,     0, 0, 1,  0, 1,  0, 32'h108,      0, 4,  3));
    vecs.push_back(mk(32'h104, 1, 1, 3'd7, 32'h104,      32'h300,     0, 0, 1,  0, 1,  0, 32'h108,      0, 5,  3));
    vecs.push_back(mk(32'h104, 1, 1, 3'd1, 32'h108,      32'h500,     1, 0, 0,  0, 0,  0, 32'h108,      0, 6,  3));
    vecs.push_back(mk(32'h108, 1, 1, 3'd4, 32'h10C,      32'h600,     1, 0, 1,  1, 0,  0, 32'h108,      0, 7,  3));
    vecs.push_back(mk(32'h10C, 1, 1, 3'd5, 32'h10C,      32'h400,     0, 0, 0,  1, 0,  1, 32'h400,      1, 8,  4));
    vecs.push_back(mk(32'h10C, 0, 0, 3'd0, 32'h0,        32'h0,       0, 0, 0,  1, 0,  0, 32'h400,      1, 8,  4));
    vecs.push_back(mk(32'h10C, 0, 0, 3'd0, 32'h0,        32'h0,       0, 0, 0,  1, 0,  0, 32'h400,      0, 8,  4));
    vecs.push_back(mk(32'h100, 1, 1, 3'd0, 32'h100,      32'h200,     0, 0, 0,  1, 0,  0, 32'h400,      0, 9,  4));
    vecs.push_back(mk(32'h100, 1, 1, 3'd0, 32'h100,      32'h200,     0, 0, 0,  1, 0,  0, 32'h400,      0, 10, 4));
    vecs.push_back(mk(32'h100, 1, 1, 3'd0, 32'h140,      32'h240,     1, 1, 0,  0, 0,  0, 32'h400,      0, 11, 4));
    vecs.push_back(mk(32'h100, 0, 0, 3'd0, 32'h0,        32'h0,       0, 0, 0,  1, 0,  0, 32'h400,      0, 11, 4));
    vecs.push_back(mk(32'h100, 1, 1, 3'd2, 32'h100,      32'h700,     0, 1, 1,  1, 1,  0, 32'h400,      0, 11, 4));
    vecs.push_back(mk(32'h100, 1, 1, 3'd3, 32'h100,      32'h700,     0, 0, 0,  1, 1,  0, 32'h400,      0, 11, 4));
    vecs.push_back(mk(32'h100, 0, 1, 3'd0, 32'h100,      32'h700,     0, 1, 0,  1, 0,  0, 32'h400,      0, 11, 4));
    vecs.push_back(mk(32'h100, 1, 1, 3'd0, 32'hFFFFFFFC, 32'h800,     1, 0, 0,  1, 0,  1, 32'h0,        1, 12, 5));
    vecs.push_back(mk(32'h100, 0, 0, 3'd0, 32'h0,        32'h0,       0, 0, 0,  1, 0,  0, 32'h0,        1, 12, 5));
    vecs.push_back(mk(32'h100, 0, 0, 3'd0, 32'h0,        32'h0,       0, 0, 0,  1, 0,  0, 32'h0,        0, 12, 5));
    drive(32'h100, 0, 0, 3'd0, 32'h0, 32'h0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_flush", 32'(bus.flush_o), 32'd0);
    chk("rst_redirect", 32'(bus.redirect_o), 32'd0);
    chk("rst_rpc", bus.redirect_pc_o, 32'd0);
    chk("rst_brcnt", bus.br_cnt_o, 32'd0);
    chk("rst_mpcnt", bus.mispred_cnt_o, 32'd0);
    chk("rst_fpred", 32'(bus.f_pred_taken_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    foreach (vecs[k]) begin
      @(negedge clk);
      drive(vecs[k].f_pc, vecs[k].v, vecs[k].br, vecs[k].f3, vecs[k].pc, vecs[k].tgt, vecs[k].pred, vecs[k].eq, vecs[k].lt);
      exp_q.push_back(vecs[k]);
      #1;
      chk($sformatf("v%0d_fpred", k), 32'(bus.f_pred_taken_o), 32'(vecs[k].e_fp));
      chk($sformatf("v%0d_brun", k), 32'(bus.br_un_o), 32'(vecs[k].e_un));
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      chk($sformatf("v%0d_redirect", k), 32'(bus.redirect_o), 32'(e.e_rd));
      chk($sformatf("v%0d_rpc", k), bus.redirect_pc_o, e.e_rpc);
      chk($sformatf("v%0d_flush", k), 32'(bus.flush_o), 32'(e.e_fl));
      chk($sformatf("v%0d_brcnt", k), bus.br_cnt_o, e.e_bc);
      chk($sformatf("v%0d_mpcnt", k), bus.mispred_cnt_o, e.e_mc);
    end
    @(negedge clk);
    drive(32'h100, 1, 1, 3'd0, 32'h100, 32'h200, 0, 1, 0);
    @(posedge clk);
    #1;
    chk("pre_rst_flush", 32'(bus.flush_o), 32'd1);
    chk("pre_rst_brcnt", bus.br_cnt_o, 32'd13);
    chk("pre_rst_fpred", 32'(bus.f_pred_taken_o), 32'd1);
    drive(32'h100, 0, 0, 3'd0, 32'h0, 32'h0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_flush", 32'(bus.flush_o), 32'd0);
    chk("mid_rst_redirect", 32'(bus.redirect_o), 32'd0);
    chk("mid_rst_rpc", bus.redirect_pc_o, 32'd0);
    chk("mid_rst_brcnt", bus.br_cnt_o, 32'd0);
    chk("mid_rst_mpcnt", bus.mispred_cnt_o, 32'd0);
    chk("mid_rst_fpred", 32'(bus.f_pred_taken_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drive(32'h100, 1, 1, 3'd0, 32'h100, 32'h200, 1, 1, 0);
    #1;
    chk("post_rst_fpred", 32'(bus.f_pred_taken_o), 32'd0);
    @(posedge clk);
    #1;
    chk("post_rst_flush", 32'(bus.flush_o), 32'd0);
    chk("post_rst_redirect", 32'(bus.redirect_o), 32'd0);
    chk("post_rst_brcnt", bus.br_cnt_o, 32'd1);
    chk("post_rst_mpcnt", bus.mispred_cnt_o, 32'd0);
    chk("post_rst_fpred2", 32'(bus.f_pred_taken_o), 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/branch_pred_ctrl.md
# branch_pred_ctrl

Branch resolution and prediction controller for the five-stage RV32I core. It sits beside the branch comparator in Execute. It drives the comparator's unsigned-select input and decodes the comparator's eq/lt flags with funct3 into a taken decision. It also keeps a direct-mapped 2-bit bimodal history table that Fetch queries, and it sequences the redirect-and-flush on a misprediction.

## Interface
Parameters:
- IDX_W, 4, history-table index width; table holds 2^IDX_W 2-bit counters, indexed by pc[IDX_W+1:2].
- FLUSH_CYC, 2, cycles flush_o stays high after a mispredict (legal range 1..15).

Ports:
- clk_i  in  1  core clock; all state is rising-edge.
- rst_n_i  in  1  reset, asynchronous, active-low.
- f_pc_i  in  32  Fetch-stage PC to predict.
- f_pred_taken_o  out  1  prediction for f_pc_i; combinational table read.
- x_valid_i  in  1  Execute holds a valid instruction.
- x_is_br_i  in  1  Execute instruction is a conditional branch.
- x_funct3_i  in  3  branch funct3.
- x_pc_i  in  32  PC of the Execute instruction.
- x_target_i  in  32  computed branch target.
- x_pred_taken_i  in  1  prediction carried down the pipe with the instruction.
- br_un_o  out  1  unsigned-compare select to the comparator; equals x_funct3_i[1].
- br_eq_i  in  1  comparator equal flag.
- br_lt_i  in  1  comparator less-than flag.
- redirect_o  out  1  one-cycle pulse: Fetch loads redirect_pc_o.
- redirect_pc_o  out  32  corrected PC, registered.
- flush_o  out  1  kill younger instructions in IF/ID/EX.
- br_cnt_o  out  32  resolved-branch count.
- mispred_cnt_o  out  32  misprediction count.

## Operation
- Taken decode:
  - 000 BEQ → eq.
  - 001 BNE → !eq.
  - 100 BLT and 110 BLTU → lt.
  - 101 BGE and 111 BGEU → !lt.
  - 010 and 011 are illegal: no resolve, no table update, no count change.
- Resolve event: x_valid_i & x_is_br_i & legal funct3 & state==IDLE.
- On a resolve:
  - Table entry at x_pc_i[IDX_W+1:2] saturates: +1 if taken (cap 11), −1 if not taken (floor 00).
  - br_cnt_o increments.
  - Mispredict = taken != x_pred_taken_i.
- On a mispredict:
  - mispred_cnt_o increments.
  - redirect_pc_o ← taken ? x_target_i : x_pc_i+4 (32-bit wrap).
  - FSM enters FLUSH.
- Prediction: f_pred_taken_o = entry[f_pc_i[IDX_W+1:2]][1].
- Same-index read and update in one cycle: the read returns the pre-update value; there is no bypass.
- FSM states:
  - IDLE: on a mispredict, go to FLUSH and load the flush counter with FLUSH_CYC−1.
  - FLUSH: flush_o=1. Execute inputs are ignored (no update, no counts, no new redirect). The counter decrements each cycle; at 0, return to IDLE.
- Counters wrap modulo 2^32.

## Timing
- Reset (async assert; synchronous release at the next edge). Values:
  - All table entries = 01 (weakly not taken).
  - state = IDLE.
  - redirect_o = 0, redirect_pc_o = 0, flush_o = 0.
  - br_cnt_o = 0, mispred_cnt_o = 0.
- Asserting reset mid-FLUSH aborts the flush immediately; flush_o drops asynchronously.
- br_un_o and f_pred_taken_o are combinational, with zero latency.
- Mispredict resolved in cycle N:
  - redirect_o=1 in cycle N+1 only, with redirect_pc_o valid.
  - flush_o=1 for cycles N+1 … N+FLUSH_CYC.
  - A branch may resolve again in cycle N+FLUSH_CYC+1.
- Table and counter updates are visible from cycle N+1.
- A correctly predicted branch produces no redirect and no flush. Back-to-back correct branches resolve every cycle.
- redirect_pc_o holds its last value when redirect_o=0.

## Test plan
- Sequence: reset, then f_pc_i=0x100, then BEQ at x_pc_i=0x100 with pred=0, eq=1, target=0x200.
  - After reset: f_pred_taken_o=0, all outputs 0.
  - After the BEQ: redirect_o pulses in N+1 with redirect_pc_o=0x200, flush_o high for N+1 and N+2, mispred_cnt_o=1, br_cnt_o=1.
  - Then f_pc_i=0x100 gives f_pred_taken_o=1.
- BGEU at 0x104 with pred=1, lt=1 → br_un_o=1; not taken; redirect_pc_o=0x108; entry[1] saturates at 00 after two such resolves.
- Branch presented during FLUSH (N+1, N+2) → ignored: counts unchanged, no second redirect. The same branch at N+3 resolves normally.
- Aliasing: taken branch at 0x140, then f_pc_i=0x100 → same index 0. The prediction reflects the 0x140 update, and a same-cycle read returns the old value.
- funct3=010 with x_valid_i=1 → no count, no table change, no redirect. Also: assert rst_n_i in the first flush cycle → flush_o=0 at once, counters 0, table back to 01.
